// File: rtl/des_key_schedule.sv
// DES round-key generator: PC-1 on load, one PC-2 subkey per round, encrypt or decrypt order.
// Optional key parity check enabled by defining DES_KEY_PARITY_CHECK_EN. Vectors are MSB-first (bit 63 of wKey = DES bit 1).
module des_key_schedule #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic        wClk,
  input  logic        wReset,
  input  logic [63:0] wKey,
  input  logic        wLoad,
  input  logic        wDecrypt,
  input  logic        wSubKeyReady,
  output logic [47:0] wSubKey,
  output logic        wSubKeyValid,
  output logic [3:0]  wRound,
  output logic        wBusy,
  output logic        wDone,
  output logic        wParityErr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // DES bit n (1-based) of a W-bit MSB-first vector lives at index W-n.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    for (int i = 0; i < 56; i++) pc1[55-i] = k[64-PC1[i]];
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    for (int i = 0; i < 48; i++) pc2[47-i] = cd[56-PC2[i]];
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] v, input logic left, input logic two);
    case ({left, two})
      2'b10:   rot = {v[26:0], v[27]};
      2'b11:   rot = {v[25:0], v[27:26]};
      2'b00:   rot = {v[0], v[27:1]};
      default: rot = {v[1:0], v[27:2]};
    endcase
  endfunction

  // Rounds K1, K2, K9 and K16 shift by one; all others by two.
  function automatic logic shift_is_one(input logic [3:0] k);
    shift_is_one = (k == 4'd0) || (k == 4'd1) || (k == 4'd8) || (k == 4'd15);
  endfunction

  logic [1:0]  state;
  logic [27:0] c_q, d_q;
  logic        dir_q;
  logic [4:0]  gcnt_q;      // subkeys generated from C/D so far, 0..16
  logic        gen_valid, gen_take, last_acc, start_ok, rot_two;
  logic [47:0] gen_key;
  logic [3:0]  gen_round;

  assign gen_valid = (state == S_RUN) && !gcnt_q[4];
  assign gen_key   = pc2({c_q, d_q});
  assign gen_round = dir_q ? (4'd15 - gcnt_q[3:0]) : gcnt_q[3:0];
  // Encrypt rotates ahead by the next round's shift, decrypt undoes the current one.
  assign rot_two   = dir_q ? !shift_is_one(gen_round) : !shift_is_one(gcnt_q[3:0] + 4'd1);

`ifdef DES_KEY_PARITY_CHECK_EN
  logic key_par_ok;
  logic perr_q;

  always_comb begin
    key_par_ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (!(^wKey[8*i +: 8])) key_par_ok = 1'b0;
  end

  always_ff @(posedge wClk) begin
    if (wReset)                        perr_q <= 1'b0;
    else if (state == S_IDLE && wLoad) perr_q <= !key_par_ok;
  end

  assign start_ok   = key_par_ok;
  assign wParityErr = perr_q;
`else
  assign start_ok   = 1'b1;
  assign wParityErr = 1'b0;
`endif

  generate
    if (OUT_REG) begin : g_out_reg
      logic        ov_q, out_free;
      logic [47:0] okey_q;
      logic [3:0]  oround_q;

      // NOTE: the output register refills whenever it is empty or being consumed,
      // which keeps back-to-back acceptance at one subkey per cycle.
      assign out_free = !ov_q || wSubKeyReady;
      assign gen_take = gen_valid && out_free;
      assign last_acc = ov_q && wSubKeyReady && gcnt_q[4];

      always_ff @(posedge wClk) begin
        if (wReset) begin
          ov_q     <= 1'b0;
          okey_q   <= '0;
          oround_q <= '0;
        end else if (state != S_RUN) begin
          ov_q <= 1'b0;
        end else if (out_free) begin
          ov_q <= gen_valid;
          if (gen_valid) begin
            okey_q   <= gen_key;
            oround_q <= gen_round;
          end
        end
      end

      assign wSubKeyValid = ov_q;
      assign wSubKey      = okey_q;
      assign wRound       = oround_q;
    end else begin : g_out_comb
      assign gen_take     = gen_valid && wSubKeyReady;
      assign last_acc     = gen_take && (gcnt_q == 5'd15);
      assign wSubKeyValid = gen_valid;
      assign wSubKey      = gen_key;
      assign wRound       = gen_round;
    end
  endgenerate

  always_ff @(posedge wClk) begin
    if (wReset) begin
      state  <= S_IDLE;
      c_q    <= '0;
      d_q    <= '0;
      dir_q  <= 1'b0;
      gcnt_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (wLoad && start_ok) begin
          {c_q, d_q} <= pc1(wKey);
          dir_q      <= wDecrypt;
          state      <= S_LOAD;
        end
        S_LOAD: begin
          if (!dir_q) begin
            c_q <= rot(c_q, 1'b1, 1'b0);
            d_q <= rot(d_q, 1'b1, 1'b0);
          end
          gcnt_q <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          if (gen_take) begin
            gcnt_q <= gcnt_q + 5'd1;
            c_q    <= rot(c_q, !dir_q, rot_two);
            d_q    <= rot(d_q, !dir_q, rot_two);
          end
          if (last_acc) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wBusy = (state != S_IDLE);
  assign wDone = (state == S_DONE);

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: directed loads push expected subkeys, a monitor pops on each accept.
// Covers encrypt/decrypt order, backpressure, mid-run reset, ignored reloads and (if DES_KEY_PARITY_CHECK_EN) parity.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_A  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Cumulative left shift of C0/D0 that produces K1..K16.
  localparam int CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  round;
  } exp_t;

  logic        wClk = 1'b0;
  logic        wReset, wLoad, wDecrypt, wSubKeyReady;
  logic [63:0] wKey;
  logic [47:0] wSubKey;
  logic        wSubKeyValid, wBusy, wDone, wParityErr;
  logic [3:0]  wRound;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  des_key_schedule dut (
    .wClk(wClk), .wReset(wReset), .wKey(wKey), .wLoad(wLoad), .wDecrypt(wDecrypt),
    .wSubKeyReady(wSubKeyReady), .wSubKey(wSubKey), .wSubKeyValid(wSubKeyValid),
    .wRound(wRound), .wBusy(wBusy), .wDone(wDone), .wParityErr(wParityErr));

  always #5 wClk = ~wClk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent model: rotate C0/D0 by the cumulative amount in one step.
  function automatic logic [47:0] model_key(input logic [63:0] key, input int k);
    bit cd0 [56];
    bit cdk [56];
    logic [47:0] r;
    int n;
    n = CUM[k];
    for (int i = 0; i < 56; i++) cd0[i] = key[64-PC1_T[i]];
    for (int j = 0; j < 28; j++) begin
      cdk[j]    = cd0[(j + n) % 28];
      cdk[28+j] = cd0[28 + (j + n) % 28];
    end
    for (int i = 0; i < 48; i++) r[47-i] = cdk[PC2_T[i]-1];
    return r;
  endfunction

  function automatic logic [47:0] exp_key(input logic [63:0] key, input int k);
    if (key == KEY_A && k == 0)  return K1_A;
    if (key == KEY_A && k == 1)  return K2_A;
    if (key == KEY_A && k == 15) return K16_A;
    return model_key(key, k);
  endfunction

  task automatic push_sched(input logic [63:0] key, input logic dec, input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.round = dec ? 4'(15 - i) : 4'(i);
      e.key   = exp_key(key, int'(e.round));
      sb.push_back(e);
    end
  endtask

  task automatic do_load(input logic [63:0] key, input logic dec);
    @(posedge wClk); #1;
    wKey = key; wDecrypt = dec; wLoad = 1'b1;
    @(posedge wClk); #1;
    wLoad = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    @(negedge wClk);
    while (!wSubKeyValid && k < 50) begin
      @(negedge wClk);
      k++;
    end
    check("valid_timeout", 64'(wSubKeyValid), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!wDone && k < 200) begin
      @(negedge wClk);
      k++;
    end
    check({name, "_done"}, 64'(wDone), 64'd1);
    @(negedge wClk);
    check({name, "_idle"}, {62'd0, wDone, wBusy}, 64'd0);
    check({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every accepted subkey must match the head of the scoreboard.
  always @(negedge wClk) begin
    if (!wReset && wSubKeyValid && wSubKeyReady) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_subkey: got %h round %0d, none expected", wSubKey, wRound);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("subkey", 64'(wSubKey), 64'(e.key));
        check("round", 64'(wRound), 64'(e.round));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    wReset = 1'b1; wLoad = 1'b0; wDecrypt = 1'b0; wSubKeyReady = 1'b0; wKey = '0;
    repeat (3) @(posedge wClk);
    #1 wReset = 1'b0;
    @(negedge wClk);
    check("reset_state", {8'd0, wSubKey, wRound, wSubKeyValid, wBusy, wDone, wParityErr}, 64'd0);

    // Encrypt, always ready: 2-cycle latency, 16 consecutive valids, done right after.
    push_sched(KEY_A, 1'b0, 16);
    wSubKeyReady = 1'b1;
    do_load(KEY_A, 1'b0);
    lat = 0;
    @(negedge wClk);
    while (!wSubKeyValid && lat < 10) begin
      @(negedge wClk);
      lat++;
    end
    check("first_latency", 64'(lat), 64'd2);
    for (int i = 1; i < 16; i++) begin
      @(negedge wClk);
      check("valid_consecutive", 64'(wSubKeyValid), 64'd1);
    end
    @(negedge wClk);
    check("done_pulse", {62'd0, wDone, wSubKeyValid}, 64'b10);
    @(negedge wClk);
    check("done_one_cycle", {62'd0, wDone, wBusy}, 64'd0);
    check("enc_sb_drained", 64'(sb.size()), 64'd0);

    // Decrypt order K16..K1.
    push_sched(KEY_A, 1'b1, 16);
    do_load(KEY_A, 1'b1);
    wait_done("decrypt");

    // Backpressure on K2 for five cycles.
    push_sched(KEY_A, 1'b0, 16);
    wSubKeyReady = 1'b0;
    do_load(KEY_A, 1'b0);
    wait_valid();
    wSubKeyReady = 1'b1;
    @(posedge wClk); #1;
    wSubKeyReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge wClk);
      check("hold_k2", {11'd0, wSubKeyValid, wRound, wSubKey}, {11'd0, 1'b1, 4'd1, K2_A});
    end
    wSubKeyReady = 1'b1;
    wait_done("backpressure");

    // Reset while K7 is presented, then a fresh encrypt run.
    push_sched(KEY_A, 1'b0, 7);
    do_load(KEY_A, 1'b0);
    lat = 0;
    @(negedge wClk);
    while (!(wSubKeyValid && wRound == 4'd6) && lat < 50) begin
      @(negedge wClk);
      lat++;
    end
    check("reached_k7", {59'd0, wSubKeyValid, wRound}, {59'd0, 1'b1, 4'd6});
    #1 wReset = 1'b1;
    @(posedge wClk); #1;
    wReset = 1'b0;
    @(negedge wClk);
    check("abort_state", {8'd0, wSubKey, wRound, wSubKeyValid, wBusy, wDone, wParityErr}, 64'd0);
    check("abort_sb_drained", 64'(sb.size()), 64'd0);
    push_sched(KEY_A, 1'b0, 16);
    do_load(KEY_A, 1'b0);
    wait_done("reload");

    // Loads of another key during RUN must be ignored.
    push_sched(KEY_A, 1'b0, 16);
    do_load(KEY_A, 1'b0);
    repeat (4) @(posedge wClk);
    #1 wKey = 64'hFEDCBA9876543210; wDecrypt = 1'b1; wLoad = 1'b1;
    repeat (3) @(posedge wClk);
    #1 wLoad = 1'b0;
    wait_done("load_ignored");

`ifdef DES_KEY_PARITY_CHECK_EN
    do_load(64'h0, 1'b0);
    @(negedge wClk);
    check("parity_flag", {62'd0, wParityErr, wBusy}, 64'b10);
    repeat (3) @(negedge wClk);
    check("parity_no_run", {61'd0, wParityErr, wBusy, wSubKeyValid}, 64'b100);
    push_sched(KEY_A, 1'b0, 16);
    do_load(KEY_A, 1'b0);
    @(negedge wClk);
    check("parity_cleared", 64'(wParityErr), 64'd0);
    wait_done("parity_good");
`else
    push_sched(64'h0, 1'b0, 16);
    do_load(64'h0, 1'b0);
    @(negedge wClk);
    check("parity_disabled", {62'd0, wParityErr, wBusy}, 64'b01);
    wait_done("zero_key");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
